// File: rtl/pc_gen.sv
// Fetch program-counter generator: holds the fetch PC, drives the instruction
// SRAM chip enable, and keeps a one-entry buffer for branches resolved during a stall.
module pc_gen #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hbfc00000,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int unsigned INC          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             ce,
  output logic             pc_adel,
  output logic             redirect_pending
);

  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_PC  = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] INC_VAL = WIDTH'(INC);

  logic [WIDTH-1:0] pending_target;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pending_target_next;
  logic             pending_valid_next;

  assign pc_plus = pc + INC_VAL;
  assign pc_adel = (pc[1:0] != 2'b00);

  // ce low means boot hold: every control input is ignored and pc stays put.
  always_comb begin
    pc_next             = pc;
    pending_valid_next  = redirect_pending;
    pending_target_next = pending_target;
    if (ce) begin
      if (exc) begin
        pc_next            = EXC_PC;
        pending_valid_next = 1'b0;
      end else if (eret) begin
        pc_next            = epc;
        pending_valid_next = 1'b0;
      end else if (en && br_taken) begin
        pc_next            = br_target;
        pending_valid_next = 1'b0;
      end else if (en && redirect_pending) begin
        pc_next            = pending_target;
        pending_valid_next = 1'b0;
      end else if (en) begin
        pc_next = pc_plus;
      end else if (br_taken) begin
        pending_valid_next  = 1'b1;
        pending_target_next = br_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce               <= 1'b0;
      pc               <= RST_PC;
      redirect_pending <= 1'b0;
      pending_target   <= '0;
    end else begin
      ce               <= 1'b1;
      pc               <= pc_next;
      redirect_pending <= pending_valid_next;
      pending_target   <= pending_target_next;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed test-plan sequences followed by random traffic,
// all checked through an expected-value queue against a reference model.
module tb_pc_gen;

  localparam int W = 32;
  localparam logic [W-1:0] RV = 32'hbfc00000;
  localparam logic [W-1:0] EV = 32'hbfc00380;
  localparam int EW = 2 * W + 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic         exc;
  logic         eret;
  logic [W-1:0] epc;
  logic         br_taken;
  logic [W-1:0] br_target;
  logic [W-1:0] pc;
  logic [W-1:0] pc_plus;
  logic         ce;
  logic         pc_adel;
  logic         redirect_pending;

  pc_gen dut (
    .clk(clk), .rst(rst), .en(en), .exc(exc), .eret(eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .pc(pc), .pc_plus(pc_plus),
    .ce(ce), .pc_adel(pc_adel), .redirect_pending(redirect_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic         m_ce;
  logic [W-1:0] m_pc;
  logic         m_pv;
  logic [W-1:0] m_pt;

  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected outputs.
  task automatic step(input logic r, input logic e, input logic x, input logic er,
                      input logic [W-1:0] ep, input logic b, input logic [W-1:0] bt);
    @(negedge clk);
    rst = r; en = e; exc = x; eret = er; epc = ep; br_taken = b; br_target = bt;
    if (r) begin
      m_ce = 1'b0; m_pc = RV; m_pv = 1'b0; m_pt = '0;
    end else if (!m_ce) begin
      m_ce = 1'b1;
    end else if (x) begin
      m_pc = EV; m_pv = 1'b0;
    end else if (er) begin
      m_pc = ep; m_pv = 1'b0;
    end else if (e) begin
      if (b) m_pc = bt;
      else if (m_pv) m_pc = m_pt;
      else m_pc = m_pc + 32'd4;
      m_pv = 1'b0;
    end else if (b) begin
      m_pv = 1'b1; m_pt = bt;
    end
    exp_q.push_back({m_pc, m_ce, m_pv, m_pc + 32'd4, (m_pc % 4) != 0});
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e[EW-1 -: W]);
        check("ce", W'(ce), W'(e[W+2]));
        check("redirect_pending", W'(redirect_pending), W'(e[W+1]));
        check("pc_plus", pc_plus, e[W:1]);
        check("pc_adel", W'(pc_adel), W'(e[0]));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; exc = 1'b0; eret = 1'b0; epc = '0;
    br_taken = 1'b0; br_target = '0;
    m_ce = 1'b0; m_pc = RV; m_pv = 1'b0; m_pt = '0;

    // reset sequence
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("reset_pc", pc, 32'hbfc00000);
    check("reset_ce", W'(ce), 32'd0);
    run(1);
    check("boot_pc", pc, 32'hbfc00000);
    check("boot_ce", W'(ce), 32'd1);
    run(1);
    check("seq_pc1", pc, 32'hbfc00004);
    run(1);
    check("seq_pc2", pc, 32'hbfc00008);
    run(2);
    check("seq_pc4", pc, 32'hbfc00010);

    // stalled branch
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hbfc00100);
    check("stall_pend", W'(redirect_pending), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    check("stall_pc", pc, 32'hbfc00010);
    run(1);
    check("pend_redirect", pc, 32'hbfc00100);
    check("pend_cleared", W'(redirect_pending), 32'd0);

    // exception over stall
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hbfc00200);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    check("exc_pc", pc, 32'hbfc00380);
    check("exc_pend", W'(redirect_pending), 32'd0);
    run(1);
    check("exc_seq", pc, 32'hbfc00384);

    // priority
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80001000, 1'b1, 32'h12345678);
    check("prio_exc", pc, 32'hbfc00380);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h80001000, 1'b1, 32'h12345678);
    check("prio_eret", pc, 32'h80001000);

    // wrap and misalignment
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hfffffffc, 1'b0, '0);
    run(1);
    check("wrap_pc", pc, 32'h00000000);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h80000002, 1'b0, '0);
    check("mis_pc", pc, 32'h80000002);
    check("mis_adel", W'(pc_adel), 32'd1);
    run(1);
    check("mis_seq", pc, 32'h80000006);

    // mid-run reset with a pending branch
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h00400000);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("mrst_pc", pc, 32'hbfc00000);
    check("mrst_ce", W'(ce), 32'd0);
    check("mrst_pend", W'(redirect_pending), 32'd0);
    run(2);
    check("mrst_restart", pc, 32'hbfc00004);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] ep;
      logic [W-1:0] bt;
      ep = $urandom;
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ep[1:0] = 2'b00;
        bt[1:0] = 2'b00;
      end
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, ep,
           $urandom_range(0, 3) == 0, bt);
    end

    // drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check("queue_drained", W'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised fetch program-counter generator for the MIPS-style core. It replaces the fixed single-register PC.
- Holds the fetch PC, produces the chip-enable for instruction SRAM, and selects the next PC: sequential, branch redirect, exception entry or ERET.
- Adds a one-entry pending-redirect buffer, so a branch resolved during a fetch stall is not lost.

Parameters:
- WIDTH, 32, PC width in bits (min 8).
- RESET_VECTOR, 32'hbfc00000, PC value held while ce is low after reset (truncated to WIDTH).
- EXC_VECTOR, 32'hbfc00380, exception entry address (truncated to WIDTH).
- INC, 4, sequential increment in bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = fetch stall.
- exc  in  1  exception flush; redirect to EXC_VECTOR.
- eret  in  1  exception return; redirect to epc.
- epc  in  WIDTH  ERET target.
- br_taken  in  1  branch/jump resolved taken.
- br_target  in  WIDTH  branch target.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus  out  WIDTH  pc + INC (combinational).
- ce  out  1  instruction-memory chip enable (registered).
- pc_adel  out  1  pc[1:0] != 0 (combinational, address-error flag).
- redirect_pending  out  1  pending branch buffer valid (registered).

Behaviour:
- Reset: when rst=1 at a clock edge, set ce<=0, pc<=RESET_VECTOR, pending_valid<=0, pending_target<=0.
- Boot: ce<=1 on the first edge with rst=0. While ce=0, pc stays at RESET_VECTOR and exc, eret, br_taken and en are all ignored (no pending capture). The first fetch is RESET_VECTOR in the cycle ce first reads 1.
- Run (ce=1): at each edge, the first matching rule applies:
  1. exc=1: pc<=EXC_VECTOR, pending cleared. Ignores en.
  2. eret=1: pc<=epc, pending cleared. Ignores en.
  3. en=1 and br_taken=1: pc<=br_target, pending cleared. The new branch wins over any pending one.
  4. en=1 and pending_valid=1: pc<=pending_target, pending cleared.
  5. en=1: pc<=pc+INC.
  6. en=0 and br_taken=1: pc holds; pending_target<=br_target, pending_valid<=1. Overwrites an existing pending entry.
  7. en=0 otherwise: pc and pending hold.
- Simultaneous events:
  - exc with eret: exc wins.
  - exc or eret with br_taken: the branch is discarded and not buffered.
- Arithmetic: pc+INC is computed modulo 2^WIDTH, so 32'hfffffffc + 4 = 32'h00000000 with no carry-out kept.
- Alignment: redirect targets are loaded unmodified. A misaligned target only raises pc_adel while it is the current pc. pc_adel does not alter PC flow.
- Latency: every redirect is visible on pc one cycle after the sampling edge.
- pc_plus and pc_adel are purely combinational from pc. All other outputs are registered.
- Reset mid-operation: rst overrides every other input in the same cycle. ce drops to 0 for at least one cycle before fetching restarts from RESET_VECTOR.

Test Plan:
- Reset sequence: rst=1 for 2 cycles, then 0, with en=1. Required: ce=0 and pc=bfc00000 during reset; ce=1 with pc=bfc00000 one cycle after release; pc=bfc00004, then bfc00008, on the following cycles.
- Stalled branch: pc=bfc00010, en=0, br_taken=1, br_target=bfc00100 for 1 cycle. Hold en=0 for 2 more cycles, then en=1. Required: redirect_pending=1 and pc=bfc00010 throughout the stall; pc=bfc00100 one cycle after en rises; redirect_pending returns to 0.
- Exception over stall: pending branch held, en=0, exc=1. Required: next pc=bfc00380 and redirect_pending=0; with en=1 afterwards, pc=bfc00384.
- Priority: exc=1, eret=1 (epc=80001000) and br_taken=1 in the same cycle. Required: pc=bfc00380. Next cycle, eret=1 with br_taken=1. Required: pc=80001000.
- Wrap and misalignment: pc=fffffffc, en=1. Required: next pc=00000000. Then eret with epc=80000002. Required: pc=80000002 and pc_adel=1; after one en=1 cycle, pc=80000006.
- Mid-run reset: pending branch held, rst=1 for 1 cycle. Required: pc=bfc00000, ce=0 and redirect_pending=0; the buffered target is never fetched.
